// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a first-word-fall-through byte FIFO.
// Flags glitched start bits (silently), framing errors and overflow.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  serial_in,
    output logic [7:0]                            data_out,
    output logic                                  data_out_valid,
    input  logic                                  data_out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       count,
    output logic                                  framing_error,
    output logic                                  overflow
);

    localparam int SYMBOL_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME = SYMBOL_TIME / 2;
    localparam int CNT_W       = $clog2(SYMBOL_TIME);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int FCNT_W      = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  SYM_LAST  = CNT_W'(SYMBOL_TIME - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic [1:0]        sync_q;
    logic              rx_s;
    state_t            state_q;
    logic [CNT_W-1:0]  clk_cnt_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              framing_error_q;
    logic              overflow_q;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [FCNT_W-1:0] count_q;
    logic [FCNT_W-1:0] count_d;

    logic push_req;
    logic push_ok;
    logic pop;

    // Synchroniser resets high so a reset never looks like a start bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
        end else begin
            framing_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q   <= START;
                        clk_cnt_q <= '0;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            clk_cnt_q <= '0;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == SYM_LAST) begin
                        shift_q   <= {rx_s, shift_q[7:1]};
                        clk_cnt_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == SYM_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q         <= WAIT_HIGH;
                            framing_error_q <= 1'b1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The byte is written on the same edge that samples a good stop bit.
    assign push_req = (state_q == STOP) && (clk_cnt_q == SYM_LAST) && rx_s;
    assign pop      = (count_q != '0) && data_out_ready;
    assign push_ok  = push_req && ((count_q != FULL_CNT) || pop);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= push_req && !push_ok;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign data_out_valid = (count_q != '0);
    assign data_out       = data_out_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign count          = count_q;
    assign framing_error  = framing_error_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 50 cycles per bit; inputs change and
// outputs are sampled on the falling clock edge.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic [3:0] count;
    logic       framing_error;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int max_count = 0;
    int streak_err = 0;
    logic prev_pop = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx_fifo dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .count          (count),
        .framing_error  (framing_error),
        .overflow       (overflow)
    );

    always #10 clk = ~clk;

    // Passive monitor: error pulses, popped bytes, peak occupancy.
    always @(negedge clk) begin
        if (framing_error) fe_cnt++;
        if (overflow) ov_cnt++;
        if (int'(count) > max_count) max_count = int'(count);
        if (data_out_valid && data_out_ready) begin
            rx_q.push_back(data_out);
            if (prev_pop) streak_err++;
            prev_pop = 1'b1;
        end else begin
            prev_pop = 1'b0;
        end
    end

    task automatic send_head(input logic [7:0] b);
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (50) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_head(b);
        serial_in = 1'b1;
        repeat (50) @(negedge clk);
    endtask

    task automatic pop_one();
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b1;
        data_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
        checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overflow); end
        $display("reset: valid=%b count=%0d data=%h", data_out_valid, count, data_out);
    endtask

    task automatic test_single_byte();
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        send_head(8'h61);
        serial_in = 1'b1;
        repeat (27) @(negedge clk);
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", data_out_valid); end
        @(negedge clk);
        checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", data_out_valid); end
        checks++; if (data_out !== 8'h61) begin errors++; $display("FAIL single_data: got %h expected 61", data_out); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        repeat (22) @(negedge clk);
        checks++; if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0) begin errors++; $display("FAIL single_no_err: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0); end
        pop_one();
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", data_out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", count); end
        $display("single: byte 61 received and popped, count=%0d", count);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        rx_q.delete();
        max_count = 0;
        streak_err = 0;
        data_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_frame(8'h61 + 8'(i));
        repeat (10) @(negedge clk);
        data_out_ready = 1'b0;
        checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d bytes expected 10", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            exp = 8'h61 + 8'(i);
            checks++; if (rx_q[i] !== exp) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp); end
        end
        checks++; if (max_count > 1) begin errors++; $display("FAIL b2b_max_count: got %0d expected <=1", max_count); end
        checks++; if (streak_err != 0) begin errors++; $display("FAIL b2b_one_cycle: got %0d long runs expected 0", streak_err); end
        $display("back_to_back: %0d bytes, max count %0d", rx_q.size(), max_count);
    endtask

    task automatic test_glitch_framing();
        int fe0 = fe_cnt;
        serial_in = 1'b0;
        repeat (10) @(negedge clk);
        serial_in = 1'b1;
        repeat (100) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", count); end
        checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL glitch_fe: got %0d pulses expected 0", fe_cnt - fe0); end
        send_head(8'hA5);
        serial_in = 1'b0;
        repeat (28) @(negedge clk);
        checks++; if (framing_error !== 1'b1) begin errors++; $display("FAIL framing_pulse: got %b expected 1", framing_error); end
        repeat (100) @(negedge clk);
        checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL framing_once: got %0d pulses expected 1", fe_cnt - fe0); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL framing_count: got %0d expected 0", count); end
        serial_in = 1'b1;
        repeat (10) @(negedge clk);
        send_frame(8'h3C);
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL recover_count: got %0d expected 1", count); end
        checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL recover_data: got %h expected 3c", data_out); end
        pop_one();
        $display("glitch_framing: framing pulses %0d, recovered byte 3c", fe_cnt - fe0);
    endtask

    task automatic test_overflow();
        int ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) send_frame(8'(i));
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_full: got %0d expected 8", count); end
        send_head(8'h08);
        serial_in = 1'b1;
        repeat (28) @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        repeat (22) @(negedge clk);
        checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL ovf_once: got %0d pulses expected 1", ov_cnt - ov0); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (data_out_valid !== 1'b1 || data_out !== 8'(i)) begin errors++; $display("FAIL ovf_drain%0d: got v=%b %h expected v=1 %h", i, data_out_valid, data_out, 8'(i)); end
            pop_one();
        end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b expected 0", data_out_valid); end
        $display("overflow: pulses %0d, drained 8", ov_cnt - ov0);
    endtask

    task automatic test_full_pop();
        int ov0 = ov_cnt;
        for (int i = 0; i < 8; i++) send_frame(8'(i));
        send_head(8'h08);
        serial_in = 1'b1;
        repeat (27) @(negedge clk);
        data_out_ready = 1'b1;
        @(negedge clk);
        data_out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ov: got %b expected 0", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fullpop_count: got %0d expected 8", count); end
        repeat (22) @(negedge clk);
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL fullpop_no_ov: got %0d pulses expected 0", ov_cnt - ov0); end
        for (int i = 1; i < 9; i++) begin
            checks++; if (data_out_valid !== 1'b1 || data_out !== 8'(i)) begin errors++; $display("FAIL fullpop_drain%0d: got v=%b %h expected v=1 %h", i, data_out_valid, data_out, 8'(i)); end
            pop_one();
        end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", data_out_valid); end
        $display("full_pop: count held at 8, drained 01..08");
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h12);
        serial_in = 1'b0;
        repeat (50) @(negedge clk);
        serial_in = 1'b1;
        repeat (225) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (data_out_valid !== 1'b0 || count !== 4'd0 || data_out !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got v=%b c=%0d d=%h expected 0 0 00", data_out_valid, count, data_out); end
        checks++; if (framing_error !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: got fe=%b ov=%b expected 0 0", framing_error, overflow); end
        repeat (244) @(negedge clk);
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midrst_no_push: got %0d expected 0", count); end
        send_frame(8'h55);
        checks++; if (count !== 4'd1 || data_out !== 8'h55) begin errors++; $display("FAIL midrst_recover: got c=%0d %h expected 1 55", count, data_out); end
        pop_one();
        $display("reset_mid_frame: frame abandoned, then byte 55 received");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch_framing();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
